pd_vote_filter: RTL and testbench
=================================

PD_VOTE_FILTER -- requirements
Module: pd_vote_filter

Interface
REQ-001 SHALL have parameter QW, default 10, width of Q and Q_next.
REQ-002 SHALL have parameter MW, default 2, width of M and the internal M counter.
REQ-003 SHALL have parameter NW, default 4, width of N and the internal N counter.
REQ-004 SHALL have parameter VOTE_TH, default 4, net votes needed for an UP or DN pulse (range 1..127).
REQ-005 SHALL have parameter LOCK_FRAMES, default 8, consecutive clean frames needed to declare lock (range 1..255).
REQ-006 Ports, one per line:
 clk_ext  in  1  sole clock, all logic on rising edge.
 Reset_PD_n  in  1  asynchronous, active-low reset.
 en  in  1  advance counters and evaluate; low = freeze all state.
 bypass  in  1  1 = no vote filtering, one UP/DN per decided frame.
 M  in  MW  inner count limit.
 N  in  NW  outer count limit.
 Q  in  QW  current delay code.
 Q_next  in  QW  next delay code.
 COMP  out  1  legacy comparison flag.
 UP  out  1  one-cycle pulse: increase delay.
 DN  out  1  one-cycle pulse: decrease delay.
 LOCK  out  1  lock indicator.
 frame_end  out  1  high on the last cycle of each frame.

Function
REQ-007 SHALL latch M and N into M_lat/N_lat at reset release and at each frame start; a value of 0 SHALL be latched as 1.
REQ-008 Counters SHALL run 1..M_lat (inner, m_cnt) and 1..N_lat (outer, n_cnt, advanced on m_cnt wrap); one frame = M_lat*N_lat enabled cycles.
REQ-009 mis = (Q != Q_next), evaluated combinationally every enabled cycle.
REQ-010 Early point = (m_cnt==1 && n_cnt==1) or (m_cnt==M_lat && n_cnt==1); late point = (m_cnt==M_lat && n_cnt==N_lat).
REQ-011 mis at an early point SHALL clear COMP and set the frame early flag; mis at a late point SHALL set COMP and the frame late flag; when one cycle is both early and late point, early SHALL take priority for COMP while both flags set.
REQ-012 frame_end SHALL be combinational high when en and the late point are true.
REQ-013 Frame decision at frame_end: late-only = +1, early-only = -1, both = 0 (conflict), neither = clean; flags SHALL clear for the next frame.
REQ-014 Vote counter SHALL be signed, saturating at +/-VOTE_TH, updated at frame_end.
REQ-015 Vote reaching +VOTE_TH SHALL produce UP high for the next cycle and return the counter to 0; -VOTE_TH likewise for DN; UP and DN SHALL never be high together.
REQ-016 With bypass=1, +1 and -1 decisions SHALL each produce UP or DN the next cycle; vote counter SHALL be held at 0.
REQ-017 FSM states ACQ, LOCKED; reset state ACQ.
REQ-018 ACQ->LOCKED after LOCK_FRAMES consecutive clean frames; any non-clean frame SHALL zero the clean counter.
REQ-019 LOCKED->ACQ on any UP or DN pulse, or on two consecutive non-clean frames; LOCK = (state==LOCKED), registered.
REQ-020 en low SHALL hold counters, flags, vote, FSM and COMP, and force UP/DN/frame_end low.
REQ-021 M or N changes mid-frame SHALL take effect only at the next frame start.

Reset
REQ-022 Reset_PD_n low SHALL immediately force COMP=0, UP=0, DN=0, LOCK=0, state ACQ, m_cnt=n_cnt=1, votes 0, clean count 0, flags 0.
REQ-023 Reset mid-frame SHALL discard the partial frame; the first frame after release SHALL start at (1,1).

Structure
REQ-024 FSM state encoding and decision encoding (+1/-1/0/clean) SHALL live in a shared package pd_pkg.
REQ-025 The frame counter (m_cnt/n_cnt/latching/point decode) SHALL be a sub-module pd_frame_cnt; vote/FSM remain in the top.

Verification
REQ-026 M=2,N=4, mis only at late point for 4 frames -> COMP=1 from first late point, exactly one UP pulse one cycle after 4th frame_end.
REQ-027 M=2,N=4, mis only at (1,1) for 4 frames -> COMP=0, one DN pulse after 4th frame_end, no UP.
REQ-028 Q==Q_next for 8 frames -> LOCK rises one cycle after 8th frame_end; one late-mis frame then one early-mis frame -> LOCK falls after the second.
REQ-029 bypass=1, alternating late/early frames -> UP, DN, UP, DN, one pulse per frame_end; N=1,M=1 with mis every cycle -> COMP=0, conflict, no pulses.
REQ-030 Reset_PD_n pulsed low mid-frame with vote=3 -> all outputs 0 immediately, next UP requires 4 fresh late frames.
REQ-031 M=0,N=0 -> treated as 1,1: frame_end every enabled cycle; en low 5 cycles -> no frame_end, state unchanged.

Source files
------------

// File: rtl/pd_pkg.sv
// rtl/pd_pkg.sv - shared types for the phase-detector vote filter
// Purpose: lock FSM state encoding, per-frame decision encoding and the
//          helper that turns the frame's early/late flags into a decision.
// Ports:   none (package).
package pd_pkg;

  typedef enum logic [0:0] {
    ST_ACQ    = 1'b0,
    ST_LOCKED = 1'b1
  } pd_state_t;

  typedef enum logic [1:0] {
    DEC_CLEAN    = 2'd0,
    DEC_PLUS     = 2'd1,
    DEC_MINUS    = 2'd2,
    DEC_CONFLICT = 2'd3
  } pd_dec_t;

  // Vote accumulator width: holds +/-127 plus one step of headroom.
  localparam int VOTE_W = 9;

  // Late-only asks for more delay, early-only for less; seeing both in one
  // frame means the sample is straddling an edge and carries no information.
  function automatic pd_dec_t pd_decide(input logic early_hit, input logic late_hit);
    pd_dec_t d;
    case ({late_hit, early_hit})
      2'b10:   d = DEC_PLUS;
      2'b01:   d = DEC_MINUS;
      2'b11:   d = DEC_CONFLICT;
      default: d = DEC_CLEAN;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pd_frame_cnt.sv
// rtl/pd_frame_cnt.sv - M x N frame counter with frame-start limit latching
// Purpose: walks m_cnt 1..M_lat (inner) and n_cnt 1..N_lat (outer), latching
//          the limits at every frame start, and decodes the sample points.
// Ports:   clk_ext, Reset_PD_n  clock / async active-low reset
//          en                   advance enable (low freezes everything)
//          M, N                 requested limits (0 is treated as 1)
//          early_pt, late_pt    current cycle is an early / late sample point
//          frame_end            en and late point: last cycle of the frame
module pd_frame_cnt #(
  parameter int MW = 2,
  parameter int NW = 4
) (
  input  logic          clk_ext,
  input  logic          Reset_PD_n,
  input  logic          en,
  input  logic [MW-1:0] M,
  input  logic [NW-1:0] N,
  output logic          early_pt,
  output logic          late_pt,
  output logic          frame_end
);

  logic [MW-1:0] m_cnt, m_lat, m_live, m_lim;
  logic [NW-1:0] n_cnt, n_lat, n_live, n_lim;
  logic          frame_start, m_wrap, n_wrap;

  assign frame_start = (m_cnt == MW'(1)) && (n_cnt == NW'(1));
  assign m_live      = (M == '0) ? MW'(1) : M;
  assign n_live      = (N == '0) ? NW'(1) : N;

  // On the first cycle of a frame the limits being latched are already in
  // force, so a 1x1 frame ends on the same cycle it starts.
  assign m_lim  = frame_start ? m_live : m_lat;
  assign n_lim  = frame_start ? n_live : n_lat;
  assign m_wrap = (m_cnt == m_lim);
  assign n_wrap = (n_cnt == n_lim);

  assign early_pt  = frame_start || (m_wrap && (n_cnt == NW'(1)));
  assign late_pt   = m_wrap && n_wrap;
  assign frame_end = en && late_pt;

  always_ff @(posedge clk_ext or negedge Reset_PD_n) begin
    if (!Reset_PD_n) begin
      m_cnt <= MW'(1);
      n_cnt <= NW'(1);
      m_lat <= MW'(1);
      n_lat <= NW'(1);
    end else if (en) begin
      if (frame_start) begin
        m_lat <= m_live;
        n_lat <= n_live;
      end
      if (m_wrap) begin
        m_cnt <= MW'(1);
        n_cnt <= n_wrap ? NW'(1) : n_cnt + NW'(1);
      end else begin
        m_cnt <= m_cnt + MW'(1);
      end
    end
  end

endmodule

// File: rtl/pd_vote_filter.sv
// rtl/pd_vote_filter.sv - phase-detector early/late vote filter with lock FSM
// Purpose: samples Q != Q_next at the frame's early and late points, turns
//          each frame into a +1/-1/conflict/clean decision, integrates the
//          decisions into UP/DN pulses and tracks lock.
// Ports:   clk_ext, Reset_PD_n  clock / async active-low reset
//          en                   advance and evaluate; low freezes all state
//          bypass               one UP/DN per decided frame, no voting
//          M, N                 inner / outer frame limits
//          Q, Q_next            current / next delay code
//          COMP                 legacy comparison flag
//          UP, DN               one-cycle adjust pulses
//          LOCK                 lock indicator
//          frame_end            last cycle of each frame
module pd_vote_filter
  import pd_pkg::*;
#(
  parameter int QW          = 10,
  parameter int MW          = 2,
  parameter int NW          = 4,
  parameter int VOTE_TH     = 4,
  parameter int LOCK_FRAMES = 8
) (
  input  logic          clk_ext,
  input  logic          Reset_PD_n,
  input  logic          en,
  input  logic          bypass,
  input  logic [MW-1:0] M,
  input  logic [NW-1:0] N,
  input  logic [QW-1:0] Q,
  input  logic [QW-1:0] Q_next,
  output logic          COMP,
  output logic          UP,
  output logic          DN,
  output logic          LOCK,
  output logic          frame_end
);

  localparam logic signed [VOTE_W-1:0] TH_P = VOTE_W'(VOTE_TH);
  localparam logic signed [VOTE_W-1:0] TH_N = -TH_P;
  localparam logic signed [VOTE_W-1:0] ONE  = VOTE_W'(1);

  logic    early_pt, late_pt;
  logic    mis, early_hit, late_hit;
  logic    ef_q, lf_q, comp_q, up_q, dn_q, up_d, dn_d;
  pd_dec_t dec;

  logic signed [VOTE_W-1:0] vote_q, vote_sum, vote_d;

  pd_state_t state_q, state_d;
  logic [7:0] clean_q, clean_d;
  logic       bad_q, bad_d;

  pd_frame_cnt #(
    .MW (MW),
    .NW (NW)
  ) u_frame_cnt (
    .clk_ext    (clk_ext),
    .Reset_PD_n (Reset_PD_n),
    .en         (en),
    .M          (M),
    .N          (N),
    .early_pt   (early_pt),
    .late_pt    (late_pt),
    .frame_end  (frame_end)
  );

  assign mis = (Q != Q_next);

  // Include this cycle's sample so the decision at frame_end sees the
  // late point that is being evaluated right now.
  assign early_hit = ef_q | (mis & early_pt);
  assign late_hit  = lf_q | (mis & late_pt);
  assign dec       = pd_decide(early_hit, late_hit);

  always_comb begin
    up_d     = 1'b0;
    dn_d     = 1'b0;
    vote_d   = vote_q;
    vote_sum = vote_q;
    case (dec)
      DEC_PLUS:  vote_sum = vote_q + ONE;
      DEC_MINUS: vote_sum = vote_q - ONE;
      default:   vote_sum = vote_q;
    endcase
    if (bypass) begin
      vote_d = '0;
      if (frame_end) begin
        up_d = (dec == DEC_PLUS);
        dn_d = (dec == DEC_MINUS);
      end
    end else if (frame_end) begin
      // Reaching the threshold fires and restarts integration from zero,
      // so the counter never actually sits at +/-VOTE_TH.
      if (vote_sum >= TH_P) begin
        up_d   = 1'b1;
        vote_d = '0;
      end else if (vote_sum <= TH_N) begin
        dn_d   = 1'b1;
        vote_d = '0;
      end else begin
        vote_d = vote_sum;
      end
    end
  end

  always_ff @(posedge clk_ext or negedge Reset_PD_n) begin
    if (!Reset_PD_n) begin
      vote_q <= '0;
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
      comp_q <= 1'b0;
      ef_q   <= 1'b0;
      lf_q   <= 1'b0;
    end else if (en) begin
      vote_q <= vote_d;
      up_q   <= up_d;
      dn_q   <= dn_d;
      // Early point wins when a 1x1 frame makes a cycle both early and late.
      if (mis && early_pt) begin
        comp_q <= 1'b0;
      end else if (mis && late_pt) begin
        comp_q <= 1'b1;
      end
      if (frame_end) begin
        ef_q <= 1'b0;
        lf_q <= 1'b0;
      end else begin
        ef_q <= early_hit;
        lf_q <= late_hit;
      end
    end else begin
      // A pulse pending while frozen is dropped rather than replayed later.
      up_q <= 1'b0;
      dn_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    clean_d = clean_q;
    bad_d   = bad_q;
    if (frame_end) begin
      case (state_q)
        ST_ACQ: begin
          if (dec == DEC_CLEAN) begin
            if ({1'b0, clean_q} + 9'd1 >= 9'(LOCK_FRAMES)) begin
              state_d = ST_LOCKED;
              clean_d = '0;
              bad_d   = 1'b0;
            end else begin
              clean_d = clean_q + 8'd1;
            end
          end else begin
            clean_d = '0;
          end
        end
        ST_LOCKED: begin
          if (up_d || dn_d) begin
            state_d = ST_ACQ;
            bad_d   = 1'b0;
          end else if (dec != DEC_CLEAN) begin
            if (bad_q) begin
              state_d = ST_ACQ;
              bad_d   = 1'b0;
            end else begin
              bad_d = 1'b1;
            end
          end else begin
            bad_d = 1'b0;
          end
        end
        default: state_d = ST_ACQ;
      endcase
    end
  end

  always_ff @(posedge clk_ext or negedge Reset_PD_n) begin
    if (!Reset_PD_n) begin
      state_q <= ST_ACQ;
      clean_q <= '0;
      bad_q   <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      clean_q <= clean_d;
      bad_q   <= bad_d;
    end
  end

  assign COMP = comp_q;
  assign UP   = up_q & en;
  assign DN   = dn_q & en;
  assign LOCK = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_pd_vote_filter.sv
// tb/tb_pd_vote_filter.sv - directed self-checking bench for pd_vote_filter
// Purpose: drives hand-built frames of early/late mismatches and checks
//          COMP, UP, DN, LOCK and frame_end against hand-computed values.
// Ports:   none (top-level bench).
module tb_pd_vote_filter;

  logic       clk_ext = 1'b0;
  logic       Reset_PD_n;
  logic       en;
  logic       bypass;
  logic [1:0] M;
  logic [3:0] N;
  logic [9:0] Q;
  logic [9:0] Q_next;
  logic       COMP, UP, DN, LOCK, frame_end;

  int   checks = 0;
  int   errors = 0;
  int   stray;
  logic fe_up, fe_dn;

  pd_vote_filter dut (
    .clk_ext    (clk_ext),
    .Reset_PD_n (Reset_PD_n),
    .en         (en),
    .bypass     (bypass),
    .M          (M),
    .N          (N),
    .Q          (Q),
    .Q_next     (Q_next),
    .COMP       (COMP),
    .UP         (UP),
    .DN         (DN),
    .LOCK       (LOCK),
    .frame_end  (frame_end)
  );

  always #5 clk_ext = ~clk_ext;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_ext);
    #1;
  endtask

  // One frame of len cycles; bit k of mask forces a mismatch on cycle k.
  // Leaves fe_up/fe_dn holding UP/DN on the cycle after frame_end.
  task automatic run_frame(input int len, input logic [31:0] mask);
    stray = 0;
    for (int k = 0; k < len; k++) begin
      if (k > 0 && (UP || DN)) stray++;
      Q_next = mask[k] ? (Q ^ 10'h001) : Q;
      #1;
      chk("frame_end_pos", frame_end, (k == len - 1));
      step();
    end
    Q_next = Q;
    fe_up  = UP;
    fe_dn  = DN;
    if (len > 1) chk("no_mid_frame_pulse", (stray == 0), 1'b1);
  endtask

  initial begin
    Reset_PD_n = 1'b0;
    en         = 1'b0;
    bypass     = 1'b0;
    M          = 2'd2;
    N          = 4'd4;
    Q          = 10'h155;
    Q_next     = 10'h155;
    step();
    step();
    chk("rst_comp", COMP, 1'b0);
    chk("rst_up", UP, 1'b0);
    chk("rst_dn", DN, 1'b0);
    chk("rst_lock", LOCK, 1'b0);
    Reset_PD_n = 1'b1;
    en         = 1'b1;

    // Late-only frames: COMP set from the first, UP after the fourth.
    for (int f = 1; f <= 4; f++) begin
      run_frame(8, 32'h80);
      chk("late_comp", COMP, 1'b1);
      chk("late_up", fe_up, (f == 4));
      chk("late_dn", fe_dn, 1'b0);
    end

    // Early-only frames at (1,1): COMP cleared, DN after the fourth.
    for (int f = 1; f <= 4; f++) begin
      run_frame(8, 32'h01);
      chk("early_comp", COMP, 1'b0);
      chk("early_dn", fe_dn, (f == 4));
      chk("early_up", fe_up, 1'b0);
    end

    // Eight clean frames lock; late then early frame drops lock.
    for (int f = 1; f <= 8; f++) begin
      run_frame(8, 32'h0);
      chk("clean_lock", LOCK, (f == 8));
    end
    run_frame(8, 32'h80);
    chk("one_bad_keeps_lock", LOCK, 1'b1);
    chk("one_bad_no_up", fe_up, 1'b0);
    run_frame(8, 32'h01);
    chk("two_bad_unlock", LOCK, 1'b0);
    chk("two_bad_no_dn", fe_dn, 1'b0);

    // Bypass: every decided frame pulses.
    bypass = 1'b1;
    for (int f = 0; f < 5; f++) begin
      run_frame(8, (f % 2 == 0) ? 32'h80 : 32'h01);
      chk("byp_up", fe_up, (f % 2 == 0));
      chk("byp_dn", fe_dn, (f % 2 == 1));
    end
    chk("byp_comp_set", COMP, 1'b1);

    // 1x1 frames with mismatch every cycle: early wins COMP, conflict.
    M = 2'd1;
    N = 4'd1;
    for (int f = 0; f < 3; f++) begin
      run_frame(1, 32'h1);
      chk("conf_comp", COMP, 1'b0);
      chk("conf_up", fe_up, 1'b0);
      chk("conf_dn", fe_dn, 1'b0);
    end

    // Vote to 3, reset mid-frame, then four fresh late frames needed.
    bypass = 1'b0;
    M = 2'd2;
    N = 4'd4;
    for (int f = 0; f < 3; f++) begin
      run_frame(8, 32'h80);
      chk("pre_rst_up", fe_up, 1'b0);
    end
    step();
    step();
    step();
    #2;
    Reset_PD_n = 1'b0;
    #1;
    chk("midrst_comp", COMP, 1'b0);
    chk("midrst_up", UP, 1'b0);
    chk("midrst_dn", DN, 1'b0);
    chk("midrst_lock", LOCK, 1'b0);
    step();
    Reset_PD_n = 1'b1;
    for (int f = 1; f <= 4; f++) begin
      run_frame(8, 32'h80);
      chk("post_rst_up", fe_up, (f == 4));
    end

    // M=N=0 acts as 1x1; en low holds flags, COMP and the clean count.
    M = 2'd0;
    N = 4'd0;
    for (int f = 0; f < 5; f++) run_frame(1, 32'h0);
    chk("zero_mn_lock", LOCK, 1'b0);
    en     = 1'b0;
    Q_next = Q ^ 10'h001;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("frozen_frame_end", frame_end, 1'b0);
      chk("frozen_up", UP, 1'b0);
      chk("frozen_comp", COMP, 1'b1);
      step();
    end
    chk("frozen_lock", LOCK, 1'b0);
    en     = 1'b1;
    Q_next = Q;
    for (int f = 6; f <= 8; f++) begin
      run_frame(1, 32'h0);
      chk("resume_lock", LOCK, (f == 8));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
